iir_coeff_loader: RTL and testbench



---
 rtl/iir_coeff_loader.sv | 180 ++++++++++++++++++
 tb/tb_iir_coeff_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_loader.sv
// iir_coeff_loader
//
// Control stage in front of the transposed 16-bit IIR section. The host fills
// a shadow bank of a[k]/b[k] coefficients. A commit then shifts that bank into
// the filter: `load` is held low for COEFF_SIZE cycles while one a/b pair is
// presented each cycle. Index 0 goes first, so it ends up in filter index 0.
//
// Optional build macro:
//   IIR_COEFF_LOADER_AUTOLOAD_EN
//     Reset loads a passthrough bank (b[0] = 0x7FFF, all other entries 0) and
//     requests a transfer, so the filter is programmed right after reset
//     release. When undefined, the bank resets to zero and nothing is
//     transferred until the host commits.
//
// Ports:
//   clk      in   system clock; all logic runs on its rising edge
//   reset    in   synchronous, active-high reset
//   wr_en    in   shadow-bank write strobe
//   wr_sel   in   selects the bank: 0 = a bank, 1 = b bank
//   wr_addr  in   coefficient index [ADDR_W]
//   wr_data  in   signed Q15 coefficient value [DATA_W]
//   commit   in   transfer request, sampled as a level on every cycle
//   wr_err   out  one-cycle pulse for a rejected write
//   busy     out  high while a transfer is in progress
//   done     out  one-cycle pulse when a transfer completes
//   load     out  to the filter: 0 = shift coefficients, 1 = run
//   cina     out  a coefficient to the filter [DATA_W]; 0 while load = 1
//   cinb     out  b coefficient to the filter [DATA_W]; 0 while load = 1
module iir_coeff_loader #(
  parameter int COEFF_SIZE = 3,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit,
  output logic              wr_err,
  output logic              busy,
  output logic              done,
  output logic              load,
  output logic [DATA_W-1:0] cina,
  output logic [DATA_W-1:0] cinb
);

  localparam int                IDX_W    = $clog2(COEFF_SIZE + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COEFF_SIZE);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(COEFF_SIZE);

`ifdef IIR_COEFF_LOADER_AUTOLOAD_EN
  localparam logic              PENDING_RST = 1'b1;
  localparam logic [DATA_W-1:0] B0_RST      = {1'b0, {(DATA_W - 1){1'b1}}};
`else
  localparam logic              PENDING_RST = 1'b0;
  localparam logic [DATA_W-1:0] B0_RST      = '0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              pending, pending_n;
  logic              load_n, busy_n, done_n, wr_err_n;
  logic [DATA_W-1:0] cina_n, cinb_n;
  logic              addr_ok, wr_ok;

  logic [DATA_W-1:0] a_bank [COEFF_SIZE];
  logic [DATA_W-1:0] b_bank [COEFF_SIZE];

  assign addr_ok = {1'b0, wr_addr} < ADDR_LIM;
  // The bank can change only while idle, so it is stable during a transfer.
  assign wr_ok   = wr_en && (state == IDLE) && addr_ok;

  // NOTE: the shadow bank lives in flops with a reset. An aborted transfer
  // must leave software with a known bank, which a RAM could not provide.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COEFF_SIZE; i++) begin
        a_bank[i] <= '0;
        b_bank[i] <= (i == 0) ? B0_RST : '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) b_bank[wr_addr] <= wr_data;
      else        a_bank[wr_addr] <= wr_data;
    end
  end

  // Next-state and registered-output values. The outputs are computed one
  // cycle early so that every port comes straight from a flop.
  // NOTE: every signal gets a default before the case statement. Without it,
  // a path that skips an assignment would infer a latch.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    load_n    = 1'b1;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    cina_n    = '0;
    cinb_n    = '0;
    wr_err_n  = wr_en && !wr_ok;

    case (state)
      IDLE: begin
        if (commit || pending) begin
          if (wr_en) begin
            // Let the write land first. The request is kept as pending, so
            // the transfer starts one cycle later and sees the new value.
            pending_n = 1'b1;
          end else begin
            state_n   = SHIFT;
            idx_n     = IDX_W'(1);
            pending_n = 1'b0;
            load_n    = 1'b0;
            busy_n    = 1'b1;
            cina_n    = a_bank[0];
            cinb_n    = b_bank[0];
          end
        end
      end

      SHIFT: begin
        busy_n = 1'b1;
        if (commit) pending_n = 1'b1;
        if (idx == LAST_IDX) begin
          state_n = DONE;
          idx_n   = '0;
          done_n  = 1'b1;
        end else begin
          load_n = 1'b0;
          cina_n = a_bank[idx];
          cinb_n = b_bank[idx];
          idx_n  = idx + IDX_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
        if (commit) pending_n = 1'b1;
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples values from before the clock edge, whatever order the
  // statements run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= PENDING_RST;
      load    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
      cina    <= '0;
      cinb    <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      load    <= load_n;
      busy    <= busy_n;
      done    <= done_n;
      wr_err  <= wr_err_n;
      cina    <= cina_n;
      cinb    <= cinb_n;
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader.
//
// The reference model works on a timeline. It remembers the cycle on which the
// current transfer started presenting coefficients. Every output is then
// derived from the offset between the current cycle and that start cycle,
// combined with a plain array copy of the shadow bank. Directed sequences run
// first, followed by a randomized phase.
module tb_iir_coeff_loader;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          commit  = 1'b0;
  logic          wr_err, busy, done, load;
  logic [DW-1:0] cina, cinb;

  always #5 clk = ~clk;

  iir_coeff_loader #(.COEFF_SIZE(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit (commit),
    .wr_err (wr_err),
    .busy   (busy),
    .done   (done),
    .load   (load),
    .cina   (cina),
    .cinb   (cinb)
  );

  int            n_vec = 0;
  int            n_mis = 0;
  int            now   = 0;
  int            start = -1000;
  bit            pend  = 1'b0;
  bit            err   = 1'b0;
  bit            armed = 1'b0;
  logic [DW-1:0] ma [N];
  logic [DW-1:0] mb [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, now, got, exp);
    end
  endtask

  task automatic model_reset();
`ifdef IIR_COEFF_LOADER_AUTOLOAD_EN
    pend = 1'b1;
`else
    pend = 1'b0;
`endif
    start = -1000;
    err   = 1'b0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
`ifdef IIR_COEFF_LOADER_AUTOLOAD_EN
    mb[0] = 16'h7FFF;
`endif
  endtask

  // Compare the DUT outputs against what the model predicts for cycle `now`.
  task automatic compare_outputs();
    int            off;
    logic          el, eb, ed;
    logic [DW-1:0] ea, ebv;
    off = now - start;
    el = 1'b1; eb = 1'b0; ed = 1'b0; ea = '0; ebv = '0;
    if (off >= 0 && off < N) begin
      el = 1'b0; eb = 1'b1; ea = ma[off]; ebv = mb[off];
    end else if (off == N) begin
      eb = 1'b1; ed = 1'b1;
    end
    check("load",   32'(load),   32'(el));
    check("busy",   32'(busy),   32'(eb));
    check("done",   32'(done),   32'(ed));
    check("wr_err", 32'(wr_err), 32'(err));
    check("cina",   32'(cina),   32'(ea));
    check("cinb",   32'(cinb),   32'(ebv));
  endtask

  // One clock cycle: check the outputs, drive the inputs, advance the model.
  task automatic step(input bit rst, input bit we, input bit sel,
                      input logic [AW-1:0] ad, input logic [DW-1:0] dat, input bit cm);
    int off;
    bit idle;
    @(negedge clk);
    if (armed) compare_outputs();
    reset   = rst;
    wr_en   = we;
    wr_sel  = sel;
    wr_addr = ad;
    wr_data = dat;
    commit  = cm;
    if (rst) begin
      model_reset();
    end else begin
      off  = now - start;
      idle = !(off >= 0 && off <= N);
      err  = we && !(idle && (int'(ad) < N));
      if (we && idle && (int'(ad) < N)) begin
        if (sel) mb[ad] = dat;
        else     ma[ad] = dat;
      end
      if (idle) begin
        if (cm || pend) begin
          if (we) begin
            pend = 1'b1;
          end else begin
            start = now + 1;
            pend  = 1'b0;
          end
        end
      end else if (cm) begin
        pend = 1'b1;
      end
    end
    now++;
    armed = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wr(input bit sel, input logic [AW-1:0] ad, input logic [DW-1:0] dat);
    step(1'b0, 1'b1, sel, ad, dat, 1'b0);
  endtask

  task automatic do_commit();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_cycles(8);  // with autoload, the automatic transfer runs here

    // Basic programming and transfer.
    wr(1'b1, 2'd0, 16'h4000); wr(1'b1, 2'd1, 16'h2000); wr(1'b1, 2'd2, 16'h1000);
    wr(1'b0, 2'd0, 16'h7FFF); wr(1'b0, 2'd1, 16'hC000); wr(1'b0, 2'd2, 16'h0800);
    do_commit();
    idle_cycles(6);

    // Write during SHIFT is rejected; a later commit shifts the original value.
    do_commit();
    wr(1'b0, 2'd1, 16'h1234);
    idle_cycles(6);
    do_commit();
    idle_cycles(6);
    // Out-of-range write in IDLE is rejected.
    wr(1'b1, 2'd3, 16'hBEEF);
    idle_cycles(2);

    // Two commits during SHIFT collapse into one extra transfer.
    do_commit();
    do_commit();
    do_commit();
    idle_cycles(12);

    // Write and commit in the same cycle: the new b[0] is presented first.
    step(1'b0, 1'b1, 1'b1, 2'd0, 16'h0100, 1'b1);
    idle_cycles(8);

    // Reset on the second SHIFT cycle, then a commit shifts zeros.
    do_commit();
    idle_cycles(1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_cycles(8);
    do_commit();
    idle_cycles(6);

    // Randomized phase.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 30,
           1'($urandom),
           AW'($urandom_range(0, 3)),
           DW'($urandom),
           $urandom_range(0, 99) < 10);
    end
    idle_cycles(10);

    @(negedge clk);
    compare_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
